// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: opcodes, ALU and bus-select
// codes, FSM state encoding and small decode helpers.
package control_unit_pkg;

  // Instruction opcodes
  localparam logic [7:0] OP_LDA_IMM = 8'h86;
  localparam logic [7:0] OP_LDA_DIR = 8'h87;
  localparam logic [7:0] OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96;
  localparam logic [7:0] OP_STB_DIR = 8'h97;
  localparam logic [7:0] OP_ADD_AB  = 8'h42;
  localparam logic [7:0] OP_SUB_AB  = 8'h43;
  localparam logic [7:0] OP_AND_AB  = 8'h44;
  localparam logic [7:0] OP_OR_AB   = 8'h45;
  localparam logic [7:0] OP_BRA     = 8'h20;
  localparam logic [7:0] OP_BMI     = 8'h21;
  localparam logic [7:0] OP_BEQ     = 8'h23;
  localparam logic [7:0] OP_BCS     = 8'h27;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;

  // Bus1 source select
  localparam logic [1:0] BUS1_PC = 2'b00;
  localparam logic [1:0] BUS1_A  = 2'b01;
  localparam logic [1:0] BUS1_B  = 2'b10;

  // Bus2 source select
  localparam logic [1:0] BUS2_ALU  = 2'b00;
  localparam logic [1:0] BUS2_BUS1 = 2'b01;
  localparam logic [1:0] BUS2_MEM  = 2'b10;

  // Controller states; A/B variants share states and are told apart by a
  // destination flag captured in DECODE.
  typedef enum logic [4:0] {
    S_FETCH_0,
    S_FETCH_1,
    S_FETCH_2,
    S_DECODE,
    S_IMM_OP_0,
    S_IMM_OP_1,
    S_IMM_LOAD,
    S_DIR_OP_0,
    S_DIR_OP_1,
    S_DIR_ADDR,
    S_DIR_WAIT,
    S_DIR_LOAD,
    S_ST_OP_0,
    S_ST_OP_1,
    S_ST_ADDR,
    S_ST_WRITE,
    S_ALU,
    S_BR_OP_0,
    S_BR_WAIT,
    S_BR_LOAD,
    S_BR_SKIP
  } state_t;

  // True when the instruction targets register B rather than A
  function automatic logic is_b_target(input logic [7:0] ir);
    return (ir == OP_LDB_IMM) || (ir == OP_LDB_DIR) || (ir == OP_STB_DIR);
  endfunction

  // ALU code for a register-register opcode; anything else maps to ADD
  function automatic logic [2:0] alu_code(input logic [7:0] ir);
    logic [2:0] code;
    case (ir)
      OP_SUB_AB: code = ALU_SUB;
      OP_AND_AB: code = ALU_AND;
      OP_OR_AB:  code = ALU_OR;
      default:   code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_unit_branch_eval.sv
// Branch-condition evaluation: decides from the opcode and the flags
// {N,Z,V,C} whether a branch instruction is taken.
module branch_eval
  import control_unit_pkg::*;
(
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       taken
);

  // No branch tests the overflow flag, so that bit is deliberately dropped.
  logic unused_ccr_v;
  assign unused_ccr_v = CCR_Result[1];

  // Select the flag that governs each conditional branch
  always_comb begin
    taken = 1'b0;
    case (IR)
      OP_BRA:  taken = 1'b1;
      OP_BMI:  taken = CCR_Result[3];
      OP_BEQ:  taken = CCR_Result[2];
      OP_BCS:  taken = CCR_Result[0];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore-style controller for the 8-bit CPU data path: fetches, decodes and
// sequences loads, stores, ALU operations and branches.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic       CCR_Load,
  output logic [2:0] ALU_Sel,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic       write
);

  state_t     state;
  state_t     next_state;
  logic       target_b;
  logic [2:0] alu_op;
  logic       taken;

  branch_eval u_branch_eval (
    .IR         (IR),
    .CCR_Result (CCR_Result),
    .taken      (taken)
  );

  // State register; destination and ALU op are frozen in DECODE so later
  // states never look at IR or the flags again.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_FETCH_0;
      target_b <= 1'b0;
      alu_op   <= ALU_ADD;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        target_b <= is_b_target(IR);
        alu_op   <= alu_code(IR);
      end
    end
  end

  // Next-state sequencing; unknown opcodes fall straight back to fetch
  always_comb begin
    next_state = S_FETCH_0;
    case (state)
      S_FETCH_0:  next_state = S_FETCH_1;
      S_FETCH_1:  next_state = S_FETCH_2;
      S_FETCH_2:  next_state = S_DECODE;
      S_DECODE: begin
        case (IR)
          OP_LDA_IMM, OP_LDB_IMM:                    next_state = S_IMM_OP_0;
          OP_LDA_DIR, OP_LDB_DIR:                    next_state = S_DIR_OP_0;
          OP_STA_DIR, OP_STB_DIR:                    next_state = S_ST_OP_0;
          OP_ADD_AB, OP_SUB_AB, OP_AND_AB, OP_OR_AB: next_state = S_ALU;
          OP_BRA, OP_BMI, OP_BEQ, OP_BCS:
            next_state = taken ? S_BR_OP_0 : S_BR_SKIP;
          default:                                   next_state = S_FETCH_0;
        endcase
      end
      S_IMM_OP_0: next_state = S_IMM_OP_1;
      S_IMM_OP_1: next_state = S_IMM_LOAD;
      S_DIR_OP_0: next_state = S_DIR_OP_1;
      S_DIR_OP_1: next_state = S_DIR_ADDR;
      S_DIR_ADDR: next_state = S_DIR_WAIT;
      S_DIR_WAIT: next_state = S_DIR_LOAD;
      S_ST_OP_0:  next_state = S_ST_OP_1;
      S_ST_OP_1:  next_state = S_ST_ADDR;
      S_ST_ADDR:  next_state = S_ST_WRITE;
      S_BR_OP_0:  next_state = S_BR_WAIT;
      S_BR_WAIT:  next_state = S_BR_LOAD;
      default:    next_state = S_FETCH_0;
    endcase
  end

  // Per-state strobes and selects, all held low while reset is asserted
  always_comb begin
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    A_Load   = 1'b0;
    B_Load   = 1'b0;
    CCR_Load = 1'b0;
    write    = 1'b0;
    ALU_Sel  = ALU_ADD;
    Bus1_Sel = BUS1_PC;
    Bus2_Sel = BUS2_ALU;
    if (reset) begin
      case (state)
        S_FETCH_0, S_IMM_OP_0, S_DIR_OP_0, S_ST_OP_0, S_BR_OP_0: begin
          Bus1_Sel = BUS1_PC;
          Bus2_Sel = BUS2_BUS1;
          MAR_Load = 1'b1;
        end
        S_FETCH_1, S_IMM_OP_1, S_DIR_OP_1, S_ST_OP_1, S_BR_SKIP: begin
          PC_Inc = 1'b1;
        end
        S_FETCH_2: begin
          Bus2_Sel = BUS2_MEM;
          IR_Load  = 1'b1;
        end
        S_DIR_ADDR, S_ST_ADDR: begin
          Bus2_Sel = BUS2_MEM;
          MAR_Load = 1'b1;
        end
        S_IMM_LOAD, S_DIR_LOAD: begin
          Bus2_Sel = BUS2_MEM;
          A_Load   = !target_b;
          B_Load   = target_b;
        end
        S_ST_WRITE: begin
          Bus1_Sel = target_b ? BUS1_B : BUS1_A;
          write    = 1'b1;
        end
        S_ALU: begin
          Bus1_Sel = BUS1_B;
          Bus2_Sel = BUS2_ALU;
          ALU_Sel  = alu_op;
          A_Load   = 1'b1;
          CCR_Load = 1'b1;
        end
        S_BR_LOAD: begin
          Bus2_Sel = BUS2_MEM;
          PC_Load  = 1'b1;
        end
        default: begin
          IR_Load = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a table of instructions with the
// expected output word for every cycle, plus hand-written reset sequences.
module tb_control_unit;

  logic       clk;
  logic       reset;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic       write;

  int assertCount = 0;
  int failCount   = 0;

  // Output word: {IR_Load,MAR_Load,PC_Load,PC_Inc,A_Load,B_Load,CCR_Load,write,
  //               ALU_Sel[2:0], Bus1_Sel[1:0], Bus2_Sel[1:0]}
  localparam logic [14:0] E_IDLE = 15'b0;
  localparam logic [14:0] E_F0   = {8'b0100_0000, 3'b000, 2'b00, 2'b01};
  localparam logic [14:0] E_F1   = {8'b0001_0000, 3'b000, 2'b00, 2'b00};
  localparam logic [14:0] E_F2   = {8'b1000_0000, 3'b000, 2'b00, 2'b10};
  localparam logic [14:0] E_ADDR = {8'b0100_0000, 3'b000, 2'b00, 2'b10};
  localparam logic [14:0] E_LDA  = {8'b0000_1000, 3'b000, 2'b00, 2'b10};
  localparam logic [14:0] E_LDB  = {8'b0000_0100, 3'b000, 2'b00, 2'b10};
  localparam logic [14:0] E_STA  = {8'b0000_0001, 3'b000, 2'b01, 2'b00};
  localparam logic [14:0] E_STB  = {8'b0000_0001, 3'b000, 2'b10, 2'b00};
  localparam logic [14:0] E_ADD  = {8'b0000_1010, 3'b000, 2'b10, 2'b00};
  localparam logic [14:0] E_SUB  = {8'b0000_1010, 3'b010, 2'b10, 2'b00};
  localparam logic [14:0] E_AND  = {8'b0000_1010, 3'b100, 2'b10, 2'b00};
  localparam logic [14:0] E_OR   = {8'b0000_1010, 3'b101, 2'b10, 2'b00};
  localparam logic [14:0] E_BRL  = {8'b0010_0000, 3'b000, 2'b00, 2'b10};

  typedef struct {
    logic [7:0]       ir;
    logic [3:0]       ccr;
    logic [3:0]       ccrLate;
    int               len;
    logic [8:0][14:0] exp;
  } vec_t;

  vec_t tbl[$];

  control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .IR         (IR),
    .CCR_Result (CCR_Result),
    .IR_Load    (IR_Load),
    .MAR_Load   (MAR_Load),
    .PC_Load    (PC_Load),
    .PC_Inc     (PC_Inc),
    .A_Load     (A_Load),
    .B_Load     (B_Load),
    .CCR_Load   (CCR_Load),
    .ALU_Sel    (ALU_Sel),
    .Bus1_Sel   (Bus1_Sel),
    .Bus2_Sel   (Bus2_Sel),
    .write      (write)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic [7:0] ir, input logic [3:0] ccr,
                               input logic [3:0] ccrLate, input int len,
                               input logic [14:0] e1, e2, e3, e4, e5, e6, e7, e8, e9);
    vec_t v;
    v.ir = ir; v.ccr = ccr; v.ccrLate = ccrLate; v.len = len;
    v.exp[0] = e1; v.exp[1] = e2; v.exp[2] = e3; v.exp[3] = e4; v.exp[4] = e5;
    v.exp[5] = e6; v.exp[6] = e7; v.exp[7] = e8; v.exp[8] = e9;
    return v;
  endfunction

  task automatic applyStimulus(input logic [7:0] ir, input logic [3:0] ccr);
    IR         = ir;
    CCR_Result = ccr;
  endtask

  task automatic checkOutput(input string name, input int cyc, input logic [14:0] expv);
    logic [14:0] act;
    act = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write,
           ALU_Sel, Bus1_Sel, Bus2_Sel};
    assertCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, act, expv);
    end
  endtask

  // Main sequence: reset, table of instructions, then reset-abort sequence
  initial begin
    logic [14:0] staExp [7];
    staExp = '{E_F0, E_F1, E_F2, E_IDLE, E_F0, E_F1, E_ADDR};

    tbl.push_back(mkv(8'h86, 4'h0, 4'h0, 7, E_F0, E_F1, E_F2, E_IDLE, E_F0, E_F1, E_LDA, E_IDLE, E_IDLE));
    tbl.push_back(mkv(8'h88, 4'h0, 4'h0, 7, E_F0, E_F1, E_F2, E_IDLE, E_F0, E_F1, E_LDB, E_IDLE, E_IDLE));
    tbl.push_back(mkv(8'h87, 4'h0, 4'h0, 9, E_F0, E_F1, E_F2, E_IDLE, E_F0, E_F1, E_ADDR, E_IDLE, E_LDA));
    tbl.push_back(mkv(8'h89, 4'h0, 4'h0, 9, E_F0, E_F1, E_F2, E_IDLE, E_F0, E_F1, E_ADDR, E_IDLE, E_LDB));
    tbl.push_back(mkv(8'h96, 4'h0, 4'h0, 8, E_F0, E_F1, E_F2, E_IDLE, E_F0, E_F1, E_ADDR, E_STA, E_IDLE));
    tbl.push_back(mkv(8'h97, 4'h0, 4'h0, 8, E_F0, E_F1, E_F2, E_IDLE, E_F0, E_F1, E_ADDR, E_STB, E_IDLE));
    tbl.push_back(mkv(8'h42, 4'h0, 4'h0, 5, E_F0, E_F1, E_F2, E_IDLE, E_ADD, E_IDLE, E_IDLE, E_IDLE, E_IDLE));
    tbl.push_back(mkv(8'h43, 4'h0, 4'h0, 5, E_F0, E_F1, E_F2, E_IDLE, E_SUB, E_IDLE, E_IDLE, E_IDLE, E_IDLE));
    tbl.push_back(mkv(8'h44, 4'h0, 4'h0, 5, E_F0, E_F1, E_F2, E_IDLE, E_AND, E_IDLE, E_IDLE, E_IDLE, E_IDLE));
    tbl.push_back(mkv(8'h45, 4'h0, 4'h0, 5, E_F0, E_F1, E_F2, E_IDLE, E_OR, E_IDLE, E_IDLE, E_IDLE, E_IDLE));
    tbl.push_back(mkv(8'h20, 4'h0, 4'h0, 7, E_F0, E_F1, E_F2, E_IDLE, E_F0, E_IDLE, E_BRL, E_IDLE, E_IDLE));
    tbl.push_back(mkv(8'h21, 4'h8, 4'h8, 7, E_F0, E_F1, E_F2, E_IDLE, E_F0, E_IDLE, E_BRL, E_IDLE, E_IDLE));
    tbl.push_back(mkv(8'h21, 4'h7, 4'h7, 5, E_F0, E_F1, E_F2, E_IDLE, E_F1, E_IDLE, E_IDLE, E_IDLE, E_IDLE));
    tbl.push_back(mkv(8'h23, 4'h4, 4'h4, 7, E_F0, E_F1, E_F2, E_IDLE, E_F0, E_IDLE, E_BRL, E_IDLE, E_IDLE));
    tbl.push_back(mkv(8'h23, 4'h0, 4'h0, 5, E_F0, E_F1, E_F2, E_IDLE, E_F1, E_IDLE, E_IDLE, E_IDLE, E_IDLE));
    tbl.push_back(mkv(8'h27, 4'h1, 4'h1, 7, E_F0, E_F1, E_F2, E_IDLE, E_F0, E_IDLE, E_BRL, E_IDLE, E_IDLE));
    tbl.push_back(mkv(8'h27, 4'hE, 4'hE, 5, E_F0, E_F1, E_F2, E_IDLE, E_F1, E_IDLE, E_IDLE, E_IDLE, E_IDLE));
    tbl.push_back(mkv(8'h23, 4'h4, 4'h0, 7, E_F0, E_F1, E_F2, E_IDLE, E_F0, E_IDLE, E_BRL, E_IDLE, E_IDLE));
    tbl.push_back(mkv(8'h23, 4'h0, 4'h4, 5, E_F0, E_F1, E_F2, E_IDLE, E_F1, E_IDLE, E_IDLE, E_IDLE, E_IDLE));
    tbl.push_back(mkv(8'h27, 4'h1, 4'h0, 7, E_F0, E_F1, E_F2, E_IDLE, E_F0, E_IDLE, E_BRL, E_IDLE, E_IDLE));
    tbl.push_back(mkv(8'hFF, 4'hF, 4'hF, 4, E_F0, E_F1, E_F2, E_IDLE, E_IDLE, E_IDLE, E_IDLE, E_IDLE, E_IDLE));
    tbl.push_back(mkv(8'h00, 4'h0, 4'h0, 4, E_F0, E_F1, E_F2, E_IDLE, E_IDLE, E_IDLE, E_IDLE, E_IDLE, E_IDLE));

    reset = 1'b0;
    applyStimulus(8'h00, 4'h0);
    repeat (3) @(negedge clk);
    #1 checkOutput("outputs held in reset", 0, E_IDLE);

    @(negedge clk);
    reset = 1'b1;
    $display("[TB] reset released, running %0d table vectors", tbl.size());

    for (int v = 0; v < tbl.size(); v++) begin
      applyStimulus(tbl[v].ir, tbl[v].ccr);
      for (int c = 0; c < tbl[v].len; c++) begin
        if (c == 4) CCR_Result = tbl[v].ccrLate;
        #1 checkOutput($sformatf("ir=%h ccr=%h/%h", tbl[v].ir, tbl[v].ccr, tbl[v].ccrLate),
                       c + 1, tbl[v].exp[c]);
        @(negedge clk);
      end
    end

    // STA_DIR interrupted by reset while in its ADDR state
    $display("[TB] reset during STA_DIR address phase");
    applyStimulus(8'h96, 4'h0);
    for (int c = 0; c < 7; c++) begin
      #1 checkOutput("STA before abort", c + 1, staExp[c]);
      if (c < 6) @(negedge clk);
    end
    reset = 1'b0;
    #1 checkOutput("reset asserted in ADDR", 7, E_IDLE);
    @(negedge clk);
    #1 checkOutput("no write while reset held", 8, E_IDLE);
    @(negedge clk);
    reset = 1'b1;
    #1 checkOutput("first cycle after reset", 1, E_F0);
    @(negedge clk);
    #1 checkOutput("second cycle after reset", 2, E_F1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
